// File: rtl/mesh_arb_pkg.sv
// Shared types and helpers for the mesh link arbiter: FSM encoding,
// ID-field default width, broadcast detection and round-robin stepping.
package mesh_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      HOLD = 2'd2
   } arb_state_t;

   localparam int ID_W_DEF = 8;

   // Arguments are zero-extended ID fields so any ID width up to 64 bits works.
   function automatic logic is_bdcst(input logic [63:0] id, input logic [63:0] bdcst_id);
      return id == bdcst_id;
   endfunction

   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set request bit at or after ptr,
// wrapping past the top index back to zero.
module rr_priority_picker #(
   parameter int NUM_IN = 4,
   localparam int PTR_W = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [PTR_W-1:0]  ptr,
   output logic              found,
   output logic [PTR_W-1:0]  idx
);

   logic [PTR_W:0] pos;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         // One extra bit of headroom keeps ptr + i from overflowing before the wrap.
         pos = {1'b0, ptr} + (PTR_W+1)'(i);
         if (pos >= (PTR_W+1)'(NUM_IN)) begin
            pos = pos - (PTR_W+1)'(NUM_IN);
         end
         if (!found && req[pos[PTR_W-1:0]]) begin
            found = 1'b1;
            idx   = pos[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mesh_link_arbiter.sv
// Round-robin arbiter sharing one outgoing mesh link among NUM_IN input FIFOs;
// the winning packet is held in a one-entry output register until popped.
module mesh_link_arbiter
   import mesh_arb_pkg::*;
#(
   parameter int               NUM_IN  = 4,
   parameter int               pckg_sz = 40,
   parameter int               ID_W    = ID_W_DEF,
   parameter logic [ID_W-1:0]  bdcst   = {ID_W{1'b1}},
   localparam int              PTR_W   = $clog2(NUM_IN)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_IN-1:0]                in_pndng,
   input  logic [NUM_IN-1:0][pckg_sz-1:0]   in_data,
   output logic [NUM_IN-1:0]                in_pop,
   output logic [pckg_sz-1:0]               out_data,
   output logic                             out_pndng,
   output logic                             out_bdcst,
   input  logic                             out_pop,
   output logic [PTR_W-1:0]                 out_grant,
   output arb_state_t                       state_dbg
);

   // Handshake: a FIFO presents pndng=1 with its head word on data (fall-through);
   // pop=1 for one cycle consumes that word at the rising edge. The output side
   // mirrors this: out_pndng/out_data is the head, out_pop consumes it.

   arb_state_t       state, state_nxt;
   logic [PTR_W-1:0] grant, grant_nxt;
   logic [PTR_W-1:0] ptr;
   logic             pick_found;
   logic [PTR_W-1:0] pick_idx;
   logic             capture;

   rr_priority_picker #(.NUM_IN(NUM_IN)) u_picker (
      .req   (in_pndng),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign state_dbg = state;
   assign capture   = (state == POP) && in_pndng[grant];

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      in_pop    = '0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               grant_nxt = pick_idx;
               state_nxt = POP;
            end
         end
         POP: begin
            // A requester that withdrew in this cycle is simply skipped.
            in_pop[grant] = in_pndng[grant];
            state_nxt     = in_pndng[grant] ? HOLD : IDLE;
         end
         HOLD: begin
            if (out_pop) begin
               if (pick_found) begin
                  grant_nxt = pick_idx;
                  state_nxt = POP;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         grant <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr       <= '0;
         out_data  <= '0;
         out_pndng <= 1'b0;
         out_bdcst <= 1'b0;
         out_grant <= '0;
      end else if (capture) begin
         out_data  <= in_data[grant];
         out_pndng <= 1'b1;
         out_bdcst <= is_bdcst(64'(in_data[grant][pckg_sz-1 -: ID_W]), 64'(bdcst));
         out_grant <= grant;
         ptr       <= PTR_W'(rr_next(32'(grant), 32'(NUM_IN)));
      end else if (state == HOLD && out_pop) begin
         out_pndng <= 1'b0;
         out_bdcst <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mesh_link_arbiter.sv
// Directed bench for mesh_link_arbiter: a per-cycle vector table followed by
// hand-written fairness, mid-operation reset and backpressure sequences.
module tb_mesh_link_arbiter;
   import mesh_arb_pkg::*;

   localparam int NUM_IN = 4;
   localparam int PW     = 40;

   localparam logic [PW-1:0] D0 = 40'h10_0000_0000;
   localparam logic [PW-1:0] D1 = 40'hFF_1234_5678;
   localparam logic [PW-1:0] D2 = 40'h01_0000_00AA;
   localparam logic [PW-1:0] D3 = 40'h03_0000_0033;

   logic                         clk = 1'b0;
   logic                         reset;
   logic [NUM_IN-1:0]            in_pndng;
   logic [NUM_IN-1:0][PW-1:0]    in_data;
   logic [NUM_IN-1:0]            in_pop;
   logic [PW-1:0]                out_data;
   logic                         out_pndng;
   logic                         out_bdcst;
   logic                         out_pop;
   logic [1:0]                   out_grant;
   arb_state_t                   state_dbg;

   int n_tests = 0;
   int n_fail  = 0;

   mesh_link_arbiter #(.NUM_IN(NUM_IN), .pckg_sz(PW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_pndng  (in_pndng),
      .in_data   (in_data),
      .in_pop    (in_pop),
      .out_data  (out_data),
      .out_pndng (out_pndng),
      .out_bdcst (out_bdcst),
      .out_pop   (out_pop),
      .out_grant (out_grant),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  pndng;
      logic        pop;
      logic [3:0]  e_pop;
      arb_state_t  e_st;
      logic        e_opnd;
      logic [1:0]  e_grant;
      logic        e_bdcst;
      logic [PW-1:0] e_data;
   } vec_t;

   vec_t vt[18];
   logic [1:0] exp_q[$];

   // ---------------- driver / checker tasks ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      next_cycle();
      next_cycle();
      reset = 1'b1;
   endtask

   // ---------------- test ----------------
   initial begin
      int cyc;
      int last_cyc;
      logic [1:0] got;
      logic [1:0] want;

      in_data[0] = D0;
      in_data[1] = D1;
      in_data[2] = D2;
      in_data[3] = D3;
      in_pndng   = '0;
      out_pop    = 1'b0;
      reset      = 1'b0;

      //            pndng    pop   e_pop    state e_opnd grant bdcst data
      vt[0]  = '{4'b0100, 1'b0, 4'b0000, IDLE, 1'b0, 2'd0, 1'b0, '0};
      vt[1]  = '{4'b0100, 1'b0, 4'b0100, POP,  1'b0, 2'd0, 1'b0, '0};
      vt[2]  = '{4'b0000, 1'b0, 4'b0000, HOLD, 1'b1, 2'd2, 1'b0, D2};
      vt[3]  = '{4'b0000, 1'b1, 4'b0000, HOLD, 1'b1, 2'd2, 1'b0, D2};
      vt[4]  = '{4'b0000, 1'b1, 4'b0000, IDLE, 1'b0, 2'd2, 1'b0, '0};
      vt[5]  = '{4'b0010, 1'b0, 4'b0000, IDLE, 1'b0, 2'd2, 1'b0, '0};
      vt[6]  = '{4'b0010, 1'b0, 4'b0010, POP,  1'b0, 2'd2, 1'b0, '0};
      vt[7]  = '{4'b0000, 1'b0, 4'b0000, HOLD, 1'b1, 2'd1, 1'b1, D1};
      vt[8]  = '{4'b1000, 1'b1, 4'b0000, HOLD, 1'b1, 2'd1, 1'b1, D1};
      vt[9]  = '{4'b1000, 1'b0, 4'b1000, POP,  1'b0, 2'd1, 1'b0, '0};
      vt[10] = '{4'b0000, 1'b0, 4'b0000, HOLD, 1'b1, 2'd3, 1'b0, D3};
      vt[11] = '{4'b0000, 1'b1, 4'b0000, HOLD, 1'b1, 2'd3, 1'b0, D3};
      vt[12] = '{4'b0100, 1'b0, 4'b0000, IDLE, 1'b0, 2'd3, 1'b0, '0};
      vt[13] = '{4'b0000, 1'b0, 4'b0000, POP,  1'b0, 2'd3, 1'b0, '0};
      vt[14] = '{4'b1010, 1'b0, 4'b0000, IDLE, 1'b0, 2'd3, 1'b0, '0};
      vt[15] = '{4'b1010, 1'b0, 4'b0010, POP,  1'b0, 2'd3, 1'b0, '0};
      vt[16] = '{4'b0000, 1'b1, 4'b0000, HOLD, 1'b1, 2'd1, 1'b1, D1};
      vt[17] = '{4'b0000, 1'b0, 4'b0000, IDLE, 1'b0, 2'd1, 1'b0, '0};

      // Reset values
      next_cycle();
      @(negedge clk);
      chk("rst in_pop", 64'(in_pop), 64'(4'b0000));
      chk("rst out_pndng", 64'(out_pndng), 64'(1'b0));
      chk("rst out_bdcst", 64'(out_bdcst), 64'(1'b0));
      chk("rst out_data", 64'(out_data), 64'(0));
      chk("rst out_grant", 64'(out_grant), 64'(0));
      chk("rst state", 64'(state_dbg), 64'(IDLE));
      next_cycle();
      reset = 1'b1;

      // Table: single request, broadcast, back-to-back, withdrawal
      for (int i = 0; i < 18; i++) begin
         in_pndng = vt[i].pndng;
         out_pop  = vt[i].pop;
         @(negedge clk);
         chk($sformatf("row%0d in_pop", i), 64'(in_pop), 64'(vt[i].e_pop));
         chk($sformatf("row%0d state", i), 64'(state_dbg), 64'(vt[i].e_st));
         chk($sformatf("row%0d out_pndng", i), 64'(out_pndng), 64'(vt[i].e_opnd));
         chk($sformatf("row%0d out_grant", i), 64'(out_grant), 64'(vt[i].e_grant));
         chk($sformatf("row%0d out_bdcst", i), 64'(out_bdcst), 64'(vt[i].e_bdcst));
         if (vt[i].e_opnd)
            chk($sformatf("row%0d out_data", i), 64'(out_data), 64'(vt[i].e_data));
         next_cycle();
      end

      // Mid-operation asynchronous reset while holding input 0's packet
      in_pndng = 4'b1111;
      out_pop  = 1'b0;
      pulse_reset();
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("mid hold state", 64'(state_dbg), 64'(HOLD));
      chk("mid hold out_data", 64'(out_data), 64'(D0));
      #2;
      reset = 1'b0;
      #1;
      chk("async rst out_pndng", 64'(out_pndng), 64'(1'b0));
      chk("async rst in_pop", 64'(in_pop), 64'(4'b0000));
      chk("async rst state", 64'(state_dbg), 64'(IDLE));
      next_cycle();
      reset   = 1'b1;
      out_pop = 1'b1;

      // Fairness with all pending and out_pop held: grants 0,1,2,3,0 every 2 cycles
      exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      last_cyc = -1;
      for (cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
         @(negedge clk);
         if (in_pop != 4'b0000) begin
            got = 2'd0;
            for (int k = 0; k < NUM_IN; k++)
               if (in_pop[k]) got = 2'(k);
            want = exp_q.pop_front();
            chk("rr onehot", 64'($countones(in_pop)), 64'(1));
            chk("rr grant", 64'(got), 64'(want));
            if (last_cyc < 0) chk("rr first latency", 64'(cyc), 64'(1));
            else              chk("rr spacing", 64'(cyc - last_cyc), 64'(2));
            last_cyc = cyc;
         end
         next_cycle();
      end
      chk("rr pulses seen", 64'(exp_q.size()), 64'(0));

      // Backpressure: hold input 0's packet for 10 cycles, then release
      out_pop  = 1'b0;
      in_pndng = 4'b0011;
      pulse_reset();
      next_cycle();
      next_cycle();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("bp%0d in_pop", c), 64'(in_pop), 64'(4'b0000));
         chk($sformatf("bp%0d out_data", c), 64'(out_data), 64'(D0));
         chk($sformatf("bp%0d out_pndng", c), 64'(out_pndng), 64'(1'b1));
         next_cycle();
      end
      out_pop = 1'b1;
      next_cycle();
      out_pop = 1'b0;
      @(negedge clk);
      chk("bp release state", 64'(state_dbg), 64'(POP));
      chk("bp release in_pop", 64'(in_pop), 64'(4'b0010));
      chk("bp release out_pndng", 64'(out_pndng), 64'(1'b0));
      next_cycle();
      @(negedge clk);
      chk("bp next out_grant", 64'(out_grant), 64'(1));
      chk("bp next out_data", 64'(out_data), 64'(D1));
      chk("bp next out_bdcst", 64'(out_bdcst), 64'(1'b1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
